clksel_ctrl: RTL and testbench

CLKSEL_CTRL -- requirements
Module: clksel_ctrl

---
 rtl/clksel_pkg.sv | 17 +
 rtl/edge_sync.sv | 28 ++
 rtl/clksel_ctrl.sv | 130 +++++++++++++
 tb/tb_clksel_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clksel_pkg.sv
// Shared definitions for the clock-select controller: default timing
// parameters and the select FSM state type.
package clksel_pkg;

  localparam int unsigned WIN_DEF     = 64;
  localparam int unsigned MINEDGE_DEF = 4;
  localparam int unsigned HOLD_DEF    = 16;

  // Encoding is {switching, select} so both outputs are raw state-flop bits.
  typedef enum logic [1:0] {
    SEL_A  = 2'b00,
    SEL_B  = 2'b01,
    HOLD_A = 2'b10,
    HOLD_B = 2'b11
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus one delay flop; pulses d_edge for one clk cycle
// per rising edge of the asynchronous input d.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic d_edge
);

  logic r_q1;
  logic r_q2;
  logic r_q3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
      r_q3 <= 1'b0;
    end else begin
      r_q1 <= d;
      r_q2 <= r_q1;
      r_q3 <= r_q2;
    end
  end

  assign d_edge = r_q2 & ~r_q3;

endmodule

// File: rtl/clksel_ctrl.sv
// Clock-source monitor and glitch-safe mux select: counts edges of clka/clkb
// per window, flags liveness, and switches select with a frozen HOLD period.
module clksel_ctrl
  import clksel_pkg::*;
#(
  parameter int unsigned WIN     = WIN_DEF,
  parameter int unsigned MINEDGE = MINEDGE_DEF,
  parameter int unsigned HOLD    = HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clka,
  input  logic clkb,
  input  logic pref,
  output logic select,
  output logic a_ok,
  output logic b_ok,
  output logic switching,
  output logic fault
);

  localparam int unsigned WW = $clog2(WIN);
  localparam int unsigned EW = $clog2(MINEDGE + 1);
  localparam int unsigned HW = $clog2(HOLD + 1);

  localparam logic [WW-1:0] WLAST = WW'(WIN - 1);
  localparam logic [EW-1:0] EMAX  = EW'(MINEDGE);
  localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);

  logic          w_a_edge;
  logic          w_b_edge;
  logic          w_wend;
  logic [WW-1:0] r_wcnt;
  logic [EW-1:0] r_acnt;
  logic [EW-1:0] r_bcnt;
  logic [EW-1:0] w_acnt_nxt;
  logic [EW-1:0] w_bcnt_nxt;
  logic          r_a_ok;
  logic          r_b_ok;
  logic          r_fault;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hcnt;
  logic [HW-1:0] w_hcnt_nxt;

  edge_sync u_sync_a (
    .clk    (clk),
    .rst    (rst),
    .d      (clka),
    .d_edge (w_a_edge)
  );

  edge_sync u_sync_b (
    .clk    (clk),
    .rst    (rst),
    .d      (clkb),
    .d_edge (w_b_edge)
  );

  function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] cnt, input logic inc);
    sat_inc = (inc && (cnt != EMAX)) ? cnt + EW'(1) : cnt;
  endfunction

  assign w_wend     = (r_wcnt == WLAST);
  assign w_acnt_nxt = sat_inc(r_acnt, w_a_edge);
  assign w_bcnt_nxt = sat_inc(r_bcnt, w_b_edge);

  // Saturation at MINEDGE turns ">= MINEDGE" into a plain equality test,
  // and the verdict uses the incremented count so a last-cycle edge counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_acnt  <= '0;
      r_bcnt  <= '0;
      r_a_ok  <= 1'b0;
      r_b_ok  <= 1'b0;
      r_fault <= 1'b0;
    end else if (w_wend) begin
      r_wcnt  <= '0;
      r_acnt  <= '0;
      r_bcnt  <= '0;
      r_a_ok  <= (w_acnt_nxt == EMAX);
      r_b_ok  <= (w_bcnt_nxt == EMAX);
      r_fault <= (w_acnt_nxt != EMAX) && (w_bcnt_nxt != EMAX);
    end else begin
      r_wcnt  <= r_wcnt + WW'(1);
      r_acnt  <= w_acnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEL_A;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = '0;
    case (r_state)
      SEL_A: begin
        if (!r_fault && r_b_ok && (pref || !r_a_ok)) w_state_nxt = HOLD_B;
      end
      SEL_B: begin
        if (!r_fault && r_a_ok && (!pref || !r_b_ok)) w_state_nxt = HOLD_A;
      end
      HOLD_A: begin
        if (r_hcnt == HLAST) w_state_nxt = SEL_A;
        else                 w_hcnt_nxt  = r_hcnt + HW'(1);
      end
      HOLD_B: begin
        if (r_hcnt == HLAST) w_state_nxt = SEL_B;
        else                 w_hcnt_nxt  = r_hcnt + HW'(1);
      end
      default: w_state_nxt = SEL_A;
    endcase
  end

  assign select    = r_state[0];
  assign switching = r_state[1];
  assign a_ok      = r_a_ok;
  assign b_ok      = r_b_ok;
  assign fault     = r_fault;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Directed bench for clksel_ctrl (WIN=64, MINEDGE=4, HOLD=16): liveness,
// preference switching, HOLD length, exact edge-count boundaries, fault, reset.
module tb_clksel_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic pref;
  logic clka;
  logic clkb;
  logic select;
  logic a_ok;
  logic b_ok;
  logic switching;
  logic fault;

  logic       a_run;
  logic       b_run;
  logic       a_man;
  logic       b_man;
  logic [1:0] a_ph = '0;
  logic [1:0] b_ph = '0;

  int n_edges = 0;
  int n_tests = 0;
  int n_fail  = 0;

  clksel_ctrl #(.WIN(64), .MINEDGE(4), .HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clka      (clka),
    .clkb      (clkb),
    .pref      (pref),
    .select    (select),
    .a_ok      (a_ok),
    .b_ok      (b_ok),
    .switching (switching),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Monitored sources run at clk/4 when enabled, otherwise follow a manual level.
  always @(negedge clk) begin
    if (a_run) a_ph = a_ph + 2'd1;
    if (b_run) b_ph = b_ph + 2'd1;
  end
  assign clka = a_run ? a_ph[1] : a_man;
  assign clkb = b_run ? b_ph[1] : b_man;

  // Edge n after reset release is the one at which the window counter reads (n-1)%64.
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges = 0;
    else     n_edges = n_edges + 1;
  end

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp_v, n_edges);
    end
  endtask

  task automatic goto_pos(input int k);
    int i;
    for (i = 0; i < 130; i++) begin
      @(negedge clk);
      if (n_edges % 64 == k) break;
    end
    if (i == 130) begin
      n_tests++;
      n_fail++;
      $error("FAIL timeout: window position %0d not reached", k);
    end
  endtask

  task automatic wait_wend();
    goto_pos(0);
  endtask

  task automatic a_pulse();
    a_man = 1'b1;
    repeat (2) @(negedge clk);
    a_man = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    pref  = 1'b0;
    a_run = 1'b1;
    b_run = 1'b0;
    a_man = 1'b0;
    b_man = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_select", select, 1'b0);
    chk("rst_a_ok", a_ok, 1'b0);
    chk("rst_b_ok", b_ok, 1'b0);
    chk("rst_switching", switching, 1'b0);
    chk("rst_fault", fault, 1'b0);
    rst = 1'b0;

    // A alive, B static, pref=0: first verdict lands exactly at edge 64
    goto_pos(63);
    chk("w1_pre_a_ok", a_ok, 1'b0);
    wait_wend();
    chk("w1_a_ok", a_ok, 1'b1);
    chk("w1_b_ok", b_ok, 1'b0);
    chk("w1_fault", fault, 1'b0);
    chk("w1_select", select, 1'b0);
    b_run = 1'b1;

    // Both alive, pref=0 keeps A; pref->1 switches with a 16-cycle HOLD
    wait_wend();
    chk("w2_b_ok", b_ok, 1'b1);
    chk("w2_a_ok", a_ok, 1'b1);
    chk("w2_select", select, 1'b0);
    repeat (3) @(negedge clk);
    chk("w2_keep_a", select, 1'b0);
    pref = 1'b1;
    #1;
    chk("pref_same_cycle_select", select, 1'b0);
    @(negedge clk);
    chk("pref_select", select, 1'b1);
    chk("pref_switching", switching, 1'b1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("hold_b_switching", switching, 1'b1);
    end
    @(negedge clk);
    chk("hold_b_done_switching", switching, 1'b0);
    chk("hold_b_done_select", select, 1'b1);

    // Stop B right at a window boundary: next verdict b_ok=0, fallback to A
    wait_wend();
    b_run = 1'b0;
    wait_wend();
    chk("bdead_b_ok", b_ok, 1'b0);
    chk("bdead_a_ok", a_ok, 1'b1);
    chk("bdead_select_before", select, 1'b1);
    @(negedge clk);
    chk("bdead_select", select, 1'b0);
    chk("bdead_switching", switching, 1'b1);
    repeat (16) @(negedge clk);
    chk("hold_a_done_switching", switching, 1'b0);
    chk("hold_a_done_select", select, 1'b0);

    // Exact edge counts on A: 3 edges -> not ok, 4 with last at wcnt 63 -> ok
    goto_pos(58);
    a_run = 1'b0;
    wait_wend();
    chk("stopA_prev_a_ok", a_ok, 1'b1);
    goto_pos(10); a_pulse();
    goto_pos(20); a_pulse();
    goto_pos(30); a_pulse();
    wait_wend();
    chk("three_edges_a_ok", a_ok, 1'b0);
    chk("three_edges_fault", fault, 1'b1);
    chk("three_edges_select", select, 1'b0);
    goto_pos(10); a_pulse();
    goto_pos(20); a_pulse();
    goto_pos(30); a_pulse();
    goto_pos(61);
    a_man = 1'b1;
    wait_wend();
    chk("four_edges_a_ok", a_ok, 1'b1);
    chk("four_edges_fault", fault, 1'b0);
    a_man = 1'b0;

    // Both dead -> fault with select held; B restarts -> fault clears, switch to B
    wait_wend();
    chk("both_dead_fault", fault, 1'b1);
    chk("both_dead_a_ok", a_ok, 1'b0);
    chk("both_dead_select", select, 1'b0);
    b_run = 1'b1;
    repeat (5) @(negedge clk);
    chk("fault_hold_select", select, 1'b0);
    chk("fault_hold_switching", switching, 1'b0);
    wait_wend();
    chk("b_back_fault", fault, 1'b0);
    chk("b_back_b_ok", b_ok, 1'b1);
    chk("b_back_select_before", select, 1'b0);
    @(negedge clk);
    chk("b_back_select", select, 1'b1);
    chk("b_back_switching", switching, 1'b1);

    // Asynchronous reset at HOLD cycle 5
    repeat (4) @(negedge clk);
    chk("hold5_switching", switching, 1'b1);
    rst = 1'b1;
    #1;
    chk("midhold_rst_select", select, 1'b0);
    chk("midhold_rst_switching", switching, 1'b0);
    chk("midhold_rst_a_ok", a_ok, 1'b0);
    chk("midhold_rst_b_ok", b_ok, 1'b0);
    chk("midhold_rst_fault", fault, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // After release the window restarts from zero
    goto_pos(63);
    chk("rel_pre_b_ok", b_ok, 1'b0);
    wait_wend();
    chk("rel_b_ok", b_ok, 1'b1);
    chk("rel_a_ok", a_ok, 1'b0);
    chk("rel_select_before", select, 1'b0);
    @(negedge clk);
    chk("rel_select", select, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
